vedic_mac: RTL and testbench

Pipelined multiply-accumulate stage built around `vedic8x8`, consuming its 16-bit products directly. Accepts a stream of 8-bit operand pairs grouped into packets by `in_last` and sums their products into a wide accumulator. Emits one result per packet, with term count and overflow flag. Sits directly downstream of the 8x8 Vedic multiplier and is the first clocked stage of the datapath.

---
 rtl/vedic_mac_if.sv | 26 ++
 rtl/vedic_mac.sv | 135 +++++++++++++
 tb/tb_vedic_mac.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/vedic_mac_if.sv
// Operand/result stream bundle for vedic_mac.
// The slave modport is the MAC side and the master modport is the producer/consumer side.
interface vedic_mac_if #(
  parameter int unsigned ACC_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic [7:0]       count;
  logic             overflow;

  modport master (
    output in_valid, a, b, in_last, out_ready,
    input  in_ready, out_valid, result, count, overflow
  );

  modport slave (
    input  in_valid, a, b, in_last, out_ready,
    output in_ready, out_valid, result, count, overflow
  );
endinterface

// File: rtl/vedic_mac.sv
// Two-stage packet multiply-accumulate.
// Operands are registered, multiplied by vedic8x8, and summed per in_last-delimited packet.
module vedic8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  // 4x4 Urdhva product from 2x2 partials: low*low, cross terms shifted by 2, high*high by 4.
  function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] q0, q1, q2, q3;
    logic [5:0] mid;
    q0  = {2'b0, x[1:0]} * {2'b0, y[1:0]};
    q1  = {2'b0, x[3:2]} * {2'b0, y[1:0]};
    q2  = {2'b0, x[1:0]} * {2'b0, y[3:2]};
    q3  = {2'b0, x[3:2]} * {2'b0, y[3:2]};
    mid = {2'b0, q1} + {2'b0, q2};
    return {q3, q0} + {mid, 2'b0};
  endfunction

  logic [7:0] r0, r1, r2, r3;
  logic [9:0] mid;

  always_comb begin
    r0  = vedic4(a[3:0], b[3:0]);
    r1  = vedic4(a[7:4], b[3:0]);
    r2  = vedic4(a[3:0], b[7:4]);
    r3  = vedic4(a[7:4], b[7:4]);
    mid = {2'b0, r1} + {2'b0, r2};
    p   = {r3, r0} + {2'b0, mid, 4'b0};
  end
endmodule

module vedic_mac #(
  parameter int unsigned ACC_W = 24
) (
  input logic        clk,
  input logic        rst_n,
  vedic_mac_if.slave bus
);
  logic [7:0]       s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic             s1_last_q, s1_last_d, s1_v_q, s1_v_d;
  logic [ACC_W-1:0] acc_q, acc_d, result_q, result_d;
  logic             ovf_q, ovf_d, overflow_q, overflow_d;
  logic [7:0]       cnt_q, cnt_d, count_q, count_d;
  logic             out_valid_q, out_valid_d;

  logic [15:0]      prod;
  logic [ACC_W:0]   sum;
  logic             ovf_n;
  logic [7:0]       cnt_n;
  logic             adv;

  vedic8x8 u_mul (
    .a (s1_a_q),
    .b (s1_b_q),
    .p (prod)
  );

  always_comb begin
    adv   = ~(out_valid_q & ~bus.out_ready);
    sum   = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, prod};
    ovf_n = ovf_q | sum[ACC_W];
    cnt_n = (cnt_q == 8'd255) ? cnt_q : cnt_q + 8'd1;

    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_last_d   = s1_last_q;
    s1_v_d      = s1_v_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;

    if (adv) begin
      s1_a_d    = bus.a;
      s1_b_d    = bus.b;
      s1_last_d = bus.in_last;
      s1_v_d    = bus.in_valid;
      // adv with out_valid set implies out_ready, so the held result drains here.
      out_valid_d = 1'b0;
      if (s1_v_q) begin
        if (s1_last_q) begin
          result_d    = sum[ACC_W-1:0];
          overflow_d  = ovf_n;
          count_d     = cnt_n;
          out_valid_d = 1'b1;
          acc_d       = '0;
          ovf_d       = 1'b0;
          cnt_d       = 8'd0;
        end else begin
          acc_d = sum[ACC_W-1:0];
          ovf_d = ovf_n;
          cnt_d = cnt_n;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_q      <= 8'd0;
      s1_b_q      <= 8'd0;
      s1_last_q   <= 1'b0;
      s1_v_q      <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= 8'd0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      count_q     <= 8'd0;
      out_valid_q <= 1'b0;
    end else begin
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_last_q   <= s1_last_d;
      s1_v_q      <= s1_v_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_vedic_mac.sv
// Drives ACC_W=24 and ACC_W=16 instances with identical streams.
// Both instances are checked against a packet-level model built on exact integer sums.
module tb_vedic_mac;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid, in_last, out_ready;
  logic [7:0] a, b;

  always #5 clk = ~clk;

  vedic_mac_if #(.ACC_W(24)) bus24 ();
  vedic_mac_if #(.ACC_W(16)) bus16 ();

  assign bus24.in_valid  = in_valid;
  assign bus24.in_last   = in_last;
  assign bus24.a         = a;
  assign bus24.b         = b;
  assign bus24.out_ready = out_ready;
  assign bus16.in_valid  = in_valid;
  assign bus16.in_last   = in_last;
  assign bus16.a         = a;
  assign bus16.b         = b;
  assign bus16.out_ready = out_ready;

  vedic_mac #(.ACC_W(24)) dut24 (.clk(clk), .rst_n(rst_n), .bus(bus24.slave));
  vedic_mac #(.ACC_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

  int total = 0;
  int bad   = 0;

  // Model: exact running sum of the open packet, the finished packet waiting one
  // cycle to land, and the result currently presented.
  longint psum;
  int     pn;
  bit     s1_has;
  longint s1_sum;
  int     s1_n;
  bit     m_ov;
  longint r_sum;
  int     r_n;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint sat(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  task automatic model_clear();
    psum   = 0;
    pn     = 0;
    s1_has = 1'b0;
    s1_sum = 0;
    s1_n   = 0;
    m_ov   = 1'b0;
    r_sum  = 0;
    r_n    = 0;
  endtask

  // One clock: check what the DUT presents before the edge, then advance the model.
  task automatic step();
    bit rdy;
    #1;
    rdy = !(m_ov && !out_ready);
    check("in_ready24", longint'(bus24.in_ready), longint'(rdy));
    check("in_ready16", longint'(bus16.in_ready), longint'(rdy));
    check("out_valid24", longint'(bus24.out_valid), longint'(m_ov));
    check("out_valid16", longint'(bus16.out_valid), longint'(m_ov));
    if (m_ov) begin
      check("result24", longint'(bus24.result), r_sum % (64'd1 << 24));
      check("result16", longint'(bus16.result), r_sum % (64'd1 << 16));
      check("count24", longint'(bus24.count), sat(r_n));
      check("count16", longint'(bus16.count), sat(r_n));
      check("overflow24", longint'(bus24.overflow), longint'(r_sum >= (64'd1 << 24)));
      check("overflow16", longint'(bus16.overflow), longint'(r_sum >= (64'd1 << 16)));
    end
    if (rdy) begin
      m_ov = s1_has;
      if (s1_has) begin
        r_sum = s1_sum;
        r_n   = s1_n;
      end
      s1_has = 1'b0;
      if (in_valid) begin
        psum = psum + longint'(a) * longint'(b);
        pn++;
        if (in_last) begin
          s1_has = 1'b1;
          s1_sum = psum;
          s1_n   = pn;
          psum   = 0;
          pn     = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic l);
    in_valid = 1'b1;
    a        = x;
    b        = y;
    in_last  = l;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", longint'(bus24.out_valid), 0);
    check("rst_result", longint'(bus24.result), 0);
    check("rst_count", longint'(bus24.count), 0);
    check("rst_overflow", longint'(bus24.overflow), 0);
    check("rst_in_ready", longint'(bus24.in_ready), 1);
    check("rst_result16", longint'(bus16.result), 0);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_valid", longint'(bus24.out_valid), 0);
    model_clear();
    rst_n = 1'b1;
  endtask

  initial begin
    in_valid  = 1'b0;
    in_last   = 1'b0;
    a         = 8'd0;
    b         = 8'd0;
    out_ready = 1'b1;
    model_clear();
    @(negedge clk);
    reset_dut();
    idle(1);

    // Single full-scale term, one-cycle result pulse.
    send(8'd255, 8'd255, 1'b1);
    idle(1);
    check("t1_valid", longint'(bus24.out_valid), 1);
    check("t1_result", longint'(bus24.result), 65025);
    check("t1_count", longint'(bus24.count), 1);
    check("t1_overflow", longint'(bus24.overflow), 0);
    idle(1);

    // Gap inside a packet.
    send(8'd3, 8'd4, 1'b0);
    idle(2);
    send(8'd5, 8'd6, 1'b0);
    send(8'd7, 8'd8, 1'b1);
    idle(1);
    check("t2_result", longint'(bus24.result), 98);
    check("t2_count", longint'(bus24.count), 3);
    idle(1);

    // Backpressure: pair offered during stall must not be absorbed.
    out_ready = 1'b0;
    send(8'd9, 8'd9, 1'b1);
    idle(1);
    for (int i = 0; i < 5; i++) send(8'd50, 8'd50, 1'b1);
    check("t3_held", longint'(bus24.result), 81);
    out_ready = 1'b1;
    idle(1);
    send(8'd2, 8'd2, 1'b1);
    idle(1);
    check("t3_result", longint'(bus24.result), 4);
    idle(1);

    // 16-bit wrap and sticky overflow, cleared for the next packet.
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    idle(1);
    check("t4_result16", longint'(bus16.result), 64514);
    check("t4_overflow16", longint'(bus16.overflow), 1);
    check("t4_overflow24", longint'(bus24.overflow), 0);
    send(8'd1, 8'd1, 1'b1);
    idle(1);
    check("t4_next16", longint'(bus16.result), 1);
    check("t4_next_ovf16", longint'(bus16.overflow), 0);
    idle(1);

    // Back-to-back packets.
    send(8'd10, 8'd10, 1'b1);
    send(8'd1, 8'd2, 1'b0);
    send(8'd3, 8'd4, 1'b1);
    idle(1);
    check("t5_result", longint'(bus24.result), 14);
    idle(1);

    // Reset mid-packet discards the partial sum.
    send(8'd200, 8'd200, 1'b0);
    send(8'd100, 8'd100, 1'b0);
    reset_dut();
    send(8'd1, 8'd1, 1'b1);
    idle(1);
    check("t6_result", longint'(bus24.result), 1);
    check("t6_count", longint'(bus24.count), 1);
    idle(1);

    // Count saturation over a 300-term packet.
    for (int i = 0; i < 300; i++) send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), i == 299);
    idle(1);
    check("t7_count", longint'(bus24.count), 255);
    idle(1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 3) == 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
